// File: rtl/ps2_keyb_rx_if.sv
// Decoded keyboard output bundle: scan byte, prefix flags and status pulses.
interface ps2_keyb_rx_if;
  logic [7:0] scan_code;
  logic       scan_released;
  logic       scan_extended;
  logic       scan_ready;
  logic       frame_error;

  modport master (
    output scan_code, scan_released, scan_extended, scan_ready, frame_error
  );
  modport slave (
    input  scan_code, scan_released, scan_extended, scan_ready, frame_error
  );
endinterface

// File: rtl/ps2_keyb_rx.sv
// PS/2 keyboard receiver: synchronise, de-glitch clock, deframe 11-bit frames, decode E0/F0 prefixes.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyb_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic           clk_i,
  input  logic           rst,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  ps2_keyb_rx_if.master  scan_if
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic                  clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FILTER_LEN-1:0] filt_sh_q;
  logic                  filt_clk_q, filt_clk_d, fall;

  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [7:0]    code_q, code_d;
  logic          rel_q, rel_d, extf_q, extf_d;
  logic          ready_q, ready_d, err_q, err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic          par_ok_q, par_ok_d;
`endif

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_sh_q  <= '1;
      filt_clk_q <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data_i;
      dat_s2_q   <= dat_s1_q;
      filt_sh_q  <= {filt_sh_q[FILTER_LEN-2:0], clk_s2_q};
      filt_clk_q <= filt_clk_d;
    end
  end

  // Filtered clock only moves once the whole sample window agrees.
  always_comb begin
    filt_clk_d = filt_clk_q;
    if (&filt_sh_q)
      filt_clk_d = 1'b1;
    else if (~|filt_sh_q)
      filt_clk_d = 1'b0;
  end

  assign fall = filt_clk_q & ~filt_clk_d;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tmo_q     <= '0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      code_q    <= '0;
      rel_q     <= 1'b0;
      extf_q    <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_ok_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tmo_q     <= tmo_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      code_q    <= code_d;
      rel_q     <= rel_d;
      extf_q    <= extf_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_ok_q  <= par_ok_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tmo_d     = tmo_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    code_d    = code_q;
    rel_d     = rel_q;
    extf_d    = extf_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_ok_d  = par_ok_q;
`endif
    // Timeout wins over a coincident fall; it also drops pending prefixes.
    if (state_q != IDLE && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      tmo_d   = '0;
      err_d   = 1'b1;
      brk_d   = 1'b0;
      ext_d   = 1'b0;
    end else if (fall) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7)
            state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_ok_d = ^{shift_q, dat_s2_q};
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s2_q)
            err_d = 1'b1;
`ifdef PS2_PARITY_CHECK_EN
          else if (!par_ok_q)
            err_d = 1'b1;
`endif
          else if (shift_q == 8'hF0)
            brk_d = 1'b1;
          else if (shift_q == 8'hE0)
            ext_d = 1'b1;
          else begin
            code_d  = shift_q;
            rel_d   = brk_q;
            extf_d  = ext_q;
            ready_d = 1'b1;
            brk_d   = 1'b0;
            ext_d   = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  assign scan_if.scan_code     = code_q;
  assign scan_if.scan_released = rel_q;
  assign scan_if.scan_extended = extf_q;
  assign scan_if.scan_ready    = ready_q;
  assign scan_if.frame_error   = err_q;
endmodule
